fsk_mod: RTL and testbench

- Downstream consumer of the dual-carrier wave generator.
- Takes two continuously running 11-bit carrier samples: car1 is the mark / logic-1 tone, car2 is the space / logic-0 tone.
- Frames parallel bytes UART-style (start, 8 data LSB-first, stop) and switches between the two carriers per bit, producing the FSK sample stream for the DAC stage.
- Between frames it idles on the mark carrier.

---
 rtl/fsk_mod.sv | 136 +++++++++++++
 tb/tb_fsk_mod.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_mod.sv
// fsk_mod: UART-framed binary FSK modulator selecting between two carriers.
// Frames bytes as start, 8 data LSB-first, stop; idles on the mark tone.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   car1       mark-tone sample (line symbol 1)
//   car2       space-tone sample (line symbol 0)
//   din        byte to transmit
//   din_valid  din holds a byte
//   din_ready  byte can be accepted this cycle
//   mod_out    registered FSK sample
//   bit_out    registered current line symbol
//   busy       frame in progress
//   frame_done one-cycle pulse after the stop bit completes
module fsk_mod #(
    parameter int DATA_W   = 11,
    parameter int BAUD_DIV = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] car1,
    input  logic [DATA_W-1:0] car2,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] mod_out,
    output logic              bit_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    bcnt;
    logic [2:0]    bcnt_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic          bit_nx;
    logic          busy_nx;
    logic          done_nx;
    logic          last;

    assign din_ready = (state == IDLE) && !rst;
    assign last      = (cnt == CMAX);

    always_comb begin
        state_nx = state;
        cnt_nx   = last ? '0 : cnt + 1'b1;
        bcnt_nx  = bcnt;
        shreg_nx = shreg;
        bit_nx   = bit_out;
        busy_nx  = busy;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx  = '0;
                bit_nx  = 1'b1;
                busy_nx = 1'b0;
                if (din_valid) begin
                    shreg_nx = din;
                    state_nx = START;
                    bit_nx   = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            START: begin
                if (last) begin
                    state_nx = DATA;
                    bit_nx   = shreg[0];
                    bcnt_nx  = '0;
                end
            end
            DATA: begin
                if (last) begin
                    if (bcnt == 3'd7) begin
                        state_nx = STOP;
                        bit_nx   = 1'b1;
                    end else begin
                        // next LSB is bit 1 of the unshifted register
                        shreg_nx = shreg >> 1;
                        bcnt_nx  = bcnt + 3'd1;
                        bit_nx   = shreg[1];
                    end
                end
            end
            STOP: begin
                if (last) begin
                    state_nx = IDLE;
                    bit_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            bit_out    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            mod_out    <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            bcnt       <= bcnt_nx;
            shreg      <= shreg_nx;
            bit_out    <= bit_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
            // selection uses the symbol and carriers present before this edge
            mod_out    <= bit_out ? car1 : car2;
        end
    end

endmodule

// File: tb/tb_fsk_mod.sv
// tb_fsk_mod: self-checking bench for fsk_mod with BAUD_DIV = 4.
// Expected waveforms come from a symbol-index model of the UART frame.
module tb_fsk_mod;

    localparam int DW = 11;
    localparam int BD = 4;
    localparam int FL = 10 * BD;

    logic          clk;
    logic          rst;
    logic [DW-1:0] car1;
    logic [DW-1:0] car2;
    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] mod_out;
    logic          bit_out;
    logic          busy;
    logic          frame_done;

    int n_cmp;
    int n_err;
    int car_mode;

    fsk_mod #(
        .DATA_W  (DW),
        .BAUD_DIV(BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .car1      (car1),
        .car2      (car2),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .mod_out   (mod_out),
        .bit_out   (bit_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // symbol k of a frame: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic sym(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cars();
        case (car_mode)
            0: begin
                car1 = 11'h123;
                car2 = 11'h456;
            end
            1: begin
                car1 = car1 + 11'd1;
                car2 = car2 + 11'd3;
            end
            default: begin
                car1 = DW'($urandom);
                car2 = DW'($urandom);
            end
        endcase
    endtask

    // Sends byte b starting at the next edge and checks all 41 cycles
    // up to and including the frame_done cycle.
    task automatic check_frame(
        input logic [7:0] b,
        input logic       hold,
        input logic [7:0] nb
    );
        int            fd_cnt;
        int            busy_cnt;
        logic          eb;
        logic          pb;
        logic [DW-1:0] p1;
        logic [DW-1:0] p2;
        logic [DW-1:0] em;
        fd_cnt   = 0;
        busy_cnt = 0;
        pb       = 1'b1;
        din       = b;
        din_valid = 1'b1;
        for (int t = 0; t <= FL; t++) begin
            drive_cars();
            p1 = car1;
            p2 = car2;
            step();
            eb = (t < FL) ? sym(b, t / BD) : 1'b1;
            em = pb ? p1 : p2;
            n_cmp++;
            if (bit_out !== eb) begin
                n_err++;
                $display("FAIL frame_bit b=%h t=%0d got %b exp %b",
                         b, t, bit_out, eb);
            end
            n_cmp++;
            if (mod_out !== em) begin
                n_err++;
                $display("FAIL frame_mod b=%h t=%0d got %h exp %h",
                         b, t, mod_out, em);
            end
            n_cmp++;
            if (busy !== (t < FL)) begin
                n_err++;
                $display("FAIL frame_busy b=%h t=%0d got %b exp %b",
                         b, t, busy, (t < FL));
            end
            n_cmp++;
            if (din_ready !== (t == FL)) begin
                n_err++;
                $display("FAIL frame_ready b=%h t=%0d got %b exp %b",
                         b, t, din_ready, (t == FL));
            end
            n_cmp++;
            if (frame_done !== (t == FL)) begin
                n_err++;
                $display("FAIL frame_done b=%h t=%0d got %b exp %b",
                         b, t, frame_done, (t == FL));
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (t == 0) begin
                din_valid = hold;
                din       = hold ? nb : 8'($urandom);
            end
            pb = eb;
        end
        n_cmp++;
        if (fd_cnt != 1) begin
            n_err++;
            $display("FAIL done_count b=%h got %0d exp 1", b, fd_cnt);
        end
        n_cmp++;
        if (busy_cnt != FL) begin
            n_err++;
            $display("FAIL busy_len b=%h got %0d exp %0d", b, busy_cnt, FL);
        end
    endtask

    task automatic idle(input int n);
        logic [DW-1:0] p1;
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_cars();
            p1 = car1;
            step();
            n_cmp++;
            if (bit_out !== 1'b1 || busy !== 1'b0 ||
                din_ready !== 1'b1 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL idle_ctl i=%0d got bit=%b busy=%b rdy=%b fd=%b",
                         i, bit_out, busy, din_ready, frame_done);
            end
            n_cmp++;
            if (mod_out !== p1) begin
                n_err++;
                $display("FAIL idle_mod i=%0d got %h exp %h", i, mod_out, p1);
            end
        end
    endtask

    task automatic test_reset();
        car_mode  = 0;
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cars();
            step();
            n_cmp++;
            if (mod_out !== 11'h000 || bit_out !== 1'b1 || busy !== 1'b0 ||
                din_ready !== 1'b0 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_vals i=%0d got mod=%h bit=%b busy=%b rdy=%b fd=%b",
                         i, mod_out, bit_out, busy, din_ready, frame_done);
            end
        end
        rst = 1'b0;
        drive_cars();
        step();
        n_cmp++;
        if (din_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rel_ready got %b exp 1", din_ready);
        end
        n_cmp++;
        if (mod_out !== 11'h123) begin
            n_err++;
            $display("FAIL reset_rel_mod got %h exp 123", mod_out);
        end
    endtask

    task automatic test_single();
        car_mode = 0;
        check_frame(8'hA5, 1'b0, 8'h00);
        idle(2);
    endtask

    task automatic test_back_to_back();
        car_mode = 0;
        check_frame(8'hA5, 1'b1, 8'h3C);
        check_frame(8'h3C, 1'b0, 8'h00);
        idle(1);
    endtask

    task automatic test_reset_mid();
        car_mode  = 0;
        din       = 8'h5A;
        din_valid = 1'b1;
        drive_cars();
        step();
        din_valid = 1'b0;
        for (int t = 1; t < 13; t++) begin
            drive_cars();
            step();
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy_pre got %b exp 1", busy);
        end
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cars();
            step();
            n_cmp++;
            if (bit_out !== 1'b1 || mod_out !== 11'h000 || busy !== 1'b0 ||
                frame_done !== 1'b0 || din_ready !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset i=%0d got bit=%b mod=%h busy=%b fd=%b rdy=%b",
                         i, bit_out, mod_out, busy, frame_done, din_ready);
            end
        end
        rst = 1'b0;
        check_frame(8'h00, 1'b0, 8'h00);
        idle(1);
    endtask

    task automatic test_carrier_track();
        car_mode = 1;
        car1     = 11'h000;
        car2     = 11'h400;
        check_frame(8'($urandom), 1'b0, 8'h00);
        idle(3);
        check_frame(8'h96, 1'b0, 8'h00);
        idle(1);
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] nb;
        car_mode = 2;
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(0, 3));
            check_frame(8'($urandom), 1'b0, 8'h00);
        end
        b  = 8'($urandom);
        nb = 8'($urandom);
        check_frame(b, 1'b1, nb);
        check_frame(nb, 1'b0, 8'h00);
        idle(2);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        car_mode  = 0;
        rst       = 1'b1;
        car1      = '0;
        car2      = '0;
        din       = '0;
        din_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_carrier_track();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
